start_seq: RTL and testbench
============================

START_SEQ -- requirements
Module: start_seq

Interface
REQ-001 SHALL have parameters: BOOT_TIMEOUT, default 1000000, cycles allowed for boot confirm; MAX_FAILS, default 3, failed boots before lock; FALLBACK_TABLE, default 8'hFF, table forced when locked.
REQ-002 SHALL have ports: clk  in  1  system clock; rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: stb  in  1  bus strobe; we  in  1  write enable; data_in  in  16  [7:0] ctrl, [15:8] data; data_out  out  32  read data; ack  out  1  bus acknowledge.
REQ-004 SHALL have ports: restart  in  1  one-cycle pulse, soft system restart (not a reset).
REQ-005 SHALL have ports: restart_req  out  1  one-cycle pulse requesting soft restart; table_sel  out  8  effective start table; armed_out  out  1  effective armed; locked  out  1  boot-loop lock active.

Function
REQ-006 SHALL decode ctrl write bits: [0] set table from data; [1] arm; [2] disarm; [3] confirm boot; [4] clear lock.
REQ-007 SHALL apply register writes at the clk edge on which stb & we is high; ack SHALL equal stb (zero wait states).
REQ-008 SHALL drive data_out = {16'b0, fail_cnt[3:0], state[1:0], locked, armed, table} when stb & ~we, else 32'b0, combinationally.
REQ-009 SHALL implement states RUN (normal), BOOT (awaiting confirm, timer running), LOCKED.
REQ-010 RUN: restart -> BOOT, timer cleared, fail_cnt unchanged.
REQ-011 BOOT: timer increments each cycle; confirm -> RUN, fail_cnt cleared.
REQ-012 BOOT: restart, or timer == BOOT_TIMEOUT-1 without confirm = failed boot: fail_cnt+1, timer cleared.
REQ-013 Failed boot by timeout SHALL pulse restart_req for exactly one cycle (edge after the timeout cycle); failed boot by restart SHALL NOT.
REQ-014 Failed boot making fail_cnt == MAX_FAILS SHALL enter LOCKED instead; no restart_req pulse.
REQ-015 LOCKED: table_sel = FALLBACK_TABLE, armed_out = 0, locked = 1; restart and confirm ignored; timer held at 0.
REQ-016 LOCKED: clear-lock write -> RUN, fail_cnt = 0; clear-lock in RUN/BOOT has no effect.
REQ-017 Outside LOCKED: table_sel = table register, armed_out = armed register.
REQ-018 Simultaneous: restart beats confirm; confirm beats timeout; disarm beats arm; table/arm writes accepted in every state (registers update, outputs masked while LOCKED).
REQ-019 fail_cnt SHALL be 4 bits, saturating at MAX_FAILS; timer width = $clog2(BOOT_TIMEOUT), no wrap beyond BOOT_TIMEOUT-1.
REQ-020 Soft restart SHALL NOT clear table, armed, fail_cnt or state except per REQ-010..016.

Reset
REQ-021 On rst low, asynchronously: state RUN, table 0, armed 1, fail_cnt 0, timer 0, restart_req 0; hence table_sel 0, armed_out 1, locked 0.
REQ-022 Reset deasserting mid-BOOT SHALL resume in RUN with no pending restart_req.

Structure
REQ-023 State encoding (RUN=0, BOOT=1, LOCKED=2) and ctrl bit positions SHALL live in shared package start_pkg.
REQ-024 Timeout counter SHALL be sub-module start_tmr (clear, enable, terminal-count out).

Verification (BOOT_TIMEOUT=16, MAX_FAILS=3, FALLBACK_TABLE=8'hFF)
REQ-025 Reset, read -> data_out = 32'h0000_0100; write data_in=16'h0501 -> read 32'h0000_0105.
REQ-026 restart pulse, confirm write on cycle 5 -> state RUN, fail_cnt 0, no restart_req.
REQ-027 restart, no confirm -> restart_req pulse 16 cycles later, fail_cnt 1; repeat -> fail_cnt 2; third timeout -> locked=1, table_sel=8'hFF, armed_out=0, no third restart_req pulse.
REQ-028 LOCKED, restart and confirm -> no change; write 16'h0010 -> RUN, table_sel=8'h05, armed_out=1.
REQ-029 BOOT, restart and confirm same cycle -> fail_cnt+1, stays BOOT; write 16'h0006 -> armed 0.
REQ-030 Assert rst low mid-BOOT with fail_cnt 2 -> immediately all reset values, no restart_req after release.

Source files
------------

// File: rtl/start_pkg.sv
// Shared definitions for the boot-loop start sequencer: state encoding,
// control-word bit positions and the saturating failure-count helper.
package start_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BOOT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam int unsigned CTRL_SET_TABLE = 0;
    localparam int unsigned CTRL_ARM       = 1;
    localparam int unsigned CTRL_DISARM    = 2;
    localparam int unsigned CTRL_CONFIRM   = 3;
    localparam int unsigned CTRL_CLR_LOCK  = 4;

    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
        return (v >= lim) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/start_tmr.sv
// Boot-confirm timeout counter: counts while enabled, parks at LIMIT-1,
// flags terminal count. Clear has priority over enable.
module start_tmr #(
    parameter int unsigned LIMIT = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] TC_VAL = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != TC_VAL)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc_o = en_i && (cnt_q == TC_VAL);

endmodule

// File: rtl/start_seq.sv
// Start sequencer: tracks soft restarts awaiting a boot confirm, counts failed
// boots, and locks onto a fallback start table after too many in a row.
module start_seq #(
    parameter int unsigned BOOT_TIMEOUT   = 1000000,
    parameter int unsigned MAX_FAILS      = 3,
    parameter logic [7:0]  FALLBACK_TABLE = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic [15:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    input  logic        restart,
    output logic        restart_req,
    output logic [7:0]  table_sel,
    output logic        armed_out,
    output logic        locked
);

    import start_pkg::*;

    localparam logic [3:0] MAX_F = 4'(MAX_FAILS);

    state_e     state_q, state_d;
    logic [7:0] table_q, table_d;
    logic       armed_q, armed_d;
    logic [3:0] fail_cnt_q, fail_cnt_d;
    logic       restart_req_q, restart_req_d;

    logic       wr, wr_table, wr_arm, wr_disarm, wr_confirm, wr_clr;
    logic       in_boot, boot_confirm, boot_timeout, fail_evt, will_lock;
    logic [3:0] fail_inc;
    logic       tmr_tc, tmr_clr;
    logic       unused_ctrl_bits;

    assign wr         = stb & we;
    assign wr_table   = wr & data_in[CTRL_SET_TABLE];
    assign wr_arm     = wr & data_in[CTRL_ARM];
    assign wr_disarm  = wr & data_in[CTRL_DISARM];
    assign wr_confirm = wr & data_in[CTRL_CONFIRM];
    assign wr_clr     = wr & data_in[CTRL_CLR_LOCK];
    assign unused_ctrl_bits = ^data_in[7:5];

    // Priority inside BOOT: restart, then confirm, then timeout.
    assign in_boot      = (state_q == ST_BOOT);
    assign boot_confirm = in_boot & ~restart & wr_confirm;
    assign boot_timeout = in_boot & ~restart & ~wr_confirm & tmr_tc;
    assign fail_evt     = (in_boot & restart) | boot_timeout;
    assign fail_inc     = sat_inc(fail_cnt_q, MAX_F);
    assign will_lock    = fail_evt && (fail_inc >= MAX_F);

    // Any BOOT event restarts the timing window; outside BOOT it sits at zero.
    assign tmr_clr = ~in_boot | restart | wr_confirm | tmr_tc;

    start_tmr #(
        .LIMIT (BOOT_TIMEOUT)
    ) u_tmr (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (tmr_clr),
        .en_i   (in_boot),
        .tc_o   (tmr_tc)
    );

    always_comb begin
        state_d       = state_q;
        table_d       = table_q;
        armed_d       = armed_q;
        fail_cnt_d    = fail_cnt_q;
        restart_req_d = 1'b0;

        if (wr_table) begin
            table_d = data_in[15:8];
        end
        if (wr_disarm) begin
            armed_d = 1'b0;
        end else if (wr_arm) begin
            armed_d = 1'b1;
        end

        case (state_q)
            ST_RUN: begin
                if (restart) begin
                    state_d = ST_BOOT;
                end
            end
            ST_BOOT: begin
                if (fail_evt) begin
                    fail_cnt_d = fail_inc;
                    if (will_lock) begin
                        state_d = ST_LOCKED;
                    end else begin
                        restart_req_d = boot_timeout;
                    end
                end else if (boot_confirm) begin
                    state_d    = ST_RUN;
                    fail_cnt_d = 4'd0;
                end
            end
            ST_LOCKED: begin
                if (wr_clr) begin
                    state_d    = ST_RUN;
                    fail_cnt_d = 4'd0;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            table_q       <= 8'h00;
            armed_q       <= 1'b1;
            fail_cnt_q    <= 4'd0;
            restart_req_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            table_q       <= table_d;
            armed_q       <= armed_d;
            fail_cnt_q    <= fail_cnt_d;
            restart_req_q <= restart_req_d;
        end
    end

    assign locked      = (state_q == ST_LOCKED);
    assign table_sel   = locked ? FALLBACK_TABLE : table_q;
    assign armed_out   = armed_q & ~locked;
    assign restart_req = restart_req_q;
    assign ack         = stb;
    assign data_out    = (stb && !we)
                       ? {16'b0, fail_cnt_q, 2'(state_q), locked, armed_q, table_q}
                       : 32'b0;

endmodule

// File: tb/tb_start_seq.sv
// Directed bench for start_seq with a 16-cycle boot timeout and lock after 3 failures.
module tb_start_seq;

    logic        clk = 1'b0;
    logic        rst, stb, we, restart;
    logic [15:0] data_in;
    logic [31:0] data_out;
    logic        ack, restart_req, armed_out, locked;
    logic [7:0]  table_sel;

    int          checks = 0;
    int          failures = 0;
    int          req_cnt = 0;
    int          base;
    logic [31:0] rd;

    start_seq #(
        .BOOT_TIMEOUT   (16),
        .MAX_FAILS      (3),
        .FALLBACK_TABLE (8'hFF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stb         (stb),
        .we          (we),
        .data_in     (data_in),
        .data_out    (data_out),
        .ack         (ack),
        .restart     (restart),
        .restart_req (restart_req),
        .table_sel   (table_sel),
        .armed_out   (armed_out),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (restart_req === 1'b1) req_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog sim_time_exceeded got=%0t exp<200000", $time);
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] d);
        stb = 1'b1; we = 1'b1; data_in = d;
        cyc(1);
        stb = 1'b0; we = 1'b0; data_in = 16'h0;
    endtask

    task automatic rd_bus(output logic [31:0] v);
        stb = 1'b1; we = 1'b0;
        #1;
        v = data_out;
        stb = 1'b0;
        #1;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        cyc(1);
        restart = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stb = 1'b0; we = 1'b0; restart = 1'b0; data_in = 16'h0;
        #2 rst = 1'b0;
        #1;
        checks++; if (table_sel !== 8'h00) begin failures++; $display("FAIL reset_table_sel got=%h exp=00", table_sel); end
        checks++; if (armed_out !== 1'b1) begin failures++; $display("FAIL reset_armed got=%b exp=1", armed_out); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
        checks++; if (restart_req !== 1'b0) begin failures++; $display("FAIL reset_restart_req got=%b exp=0", restart_req); end
        checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL idle_data_out got=%h exp=00000000", data_out); end
        rd_bus(rd);
        checks++; if (rd !== 32'h0000_0100) begin failures++; $display("FAIL reset_read got=%h exp=00000100", rd); end
        cyc(2);
        rst = 1'b1;
        cyc(1);
    endtask

    task automatic test_table_write();
        stb = 1'b1; we = 1'b1; data_in = 16'h0501;
        #1;
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL ack_on_write got=%b exp=1", ack); end
        cyc(1);
        stb = 1'b0; we = 1'b0; data_in = 16'h0;
        #1;
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL ack_idle got=%b exp=0", ack); end
        rd_bus(rd);
        checks++; if (rd !== 32'h0000_0105) begin failures++; $display("FAIL table_write_read got=%h exp=00000105", rd); end
        checks++; if (table_sel !== 8'h05) begin failures++; $display("FAIL table_sel_run got=%h exp=05", table_sel); end
    endtask

    task automatic test_confirm();
        base = req_cnt;
        pulse_restart();
        rd_bus(rd);
        checks++; if (rd !== 32'h0000_0505) begin failures++; $display("FAIL confirm_boot_state got=%h exp=00000505", rd); end
        cyc(4);
        wr(16'h0008);
        rd_bus(rd);
        checks++; if (rd !== 32'h0000_0105) begin failures++; $display("FAIL confirm_back_to_run got=%h exp=00000105", rd); end
        cyc(20);
        checks++; if (req_cnt != base) begin failures++; $display("FAIL confirm_no_req got=%0d exp=%0d", req_cnt, base); end
        rd_bus(rd);
        checks++; if (rd !== 32'h0000_0105) begin failures++; $display("FAIL confirm_stays_run got=%h exp=00000105", rd); end
    endtask

    task automatic test_timeout();
        base = req_cnt;
        pulse_restart();
        cyc(15);
        checks++; if (restart_req !== 1'b0) begin failures++; $display("FAIL timeout_early_req got=%b exp=0", restart_req); end
        cyc(1);
        checks++; if (restart_req !== 1'b1) begin failures++; $display("FAIL timeout1_req got=%b exp=1", restart_req); end
        rd_bus(rd);
        checks++; if (rd !== 32'h0000_1505) begin failures++; $display("FAIL timeout1_read got=%h exp=00001505", rd); end
        cyc(1);
        checks++; if (restart_req !== 1'b0) begin failures++; $display("FAIL timeout1_pulse_width got=%b exp=0", restart_req); end
        cyc(15);
        checks++; if (restart_req !== 1'b1) begin failures++; $display("FAIL timeout2_req got=%b exp=1", restart_req); end
        rd_bus(rd);
        checks++; if (rd !== 32'h0000_2505) begin failures++; $display("FAIL timeout2_read got=%h exp=00002505", rd); end
        cyc(16);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL timeout3_locked got=%b exp=1", locked); end
        checks++; if (restart_req !== 1'b0) begin failures++; $display("FAIL timeout3_no_req got=%b exp=0", restart_req); end
        checks++; if (table_sel !== 8'hFF) begin failures++; $display("FAIL locked_table_sel got=%h exp=ff", table_sel); end
        checks++; if (armed_out !== 1'b0) begin failures++; $display("FAIL locked_armed got=%b exp=0", armed_out); end
        rd_bus(rd);
        checks++; if (rd !== 32'h0000_3B05) begin failures++; $display("FAIL locked_read got=%h exp=00003b05", rd); end
        cyc(4);
        checks++; if (req_cnt - base != 2) begin failures++; $display("FAIL timeout_pulse_count got=%0d exp=2", req_cnt - base); end
    endtask

    task automatic test_locked();
        base = req_cnt;
        pulse_restart();
        wr(16'h0008);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL locked_ignores_events got=%b exp=1", locked); end
        rd_bus(rd);
        checks++; if (rd !== 32'h0000_3B05) begin failures++; $display("FAIL locked_unchanged_read got=%h exp=00003b05", rd); end
        wr(16'h0901);
        checks++; if (table_sel !== 8'hFF) begin failures++; $display("FAIL locked_table_masked got=%h exp=ff", table_sel); end
        rd_bus(rd);
        checks++; if (rd !== 32'h0000_3B09) begin failures++; $display("FAIL locked_table_reg got=%h exp=00003b09", rd); end
        wr(16'h0004);
        rd_bus(rd);
        checks++; if (rd !== 32'h0000_3A09) begin failures++; $display("FAIL locked_disarm_reg got=%h exp=00003a09", rd); end
        wr(16'h0503);
        wr(16'h0010);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL clear_lock got=%b exp=0", locked); end
        checks++; if (table_sel !== 8'h05) begin failures++; $display("FAIL clear_table_sel got=%h exp=05", table_sel); end
        checks++; if (armed_out !== 1'b1) begin failures++; $display("FAIL clear_armed got=%b exp=1", armed_out); end
        rd_bus(rd);
        checks++; if (rd !== 32'h0000_0105) begin failures++; $display("FAIL clear_read got=%h exp=00000105", rd); end
        wr(16'h0010);
        rd_bus(rd);
        checks++; if (rd !== 32'h0000_0105) begin failures++; $display("FAIL clear_in_run got=%h exp=00000105", rd); end
        checks++; if (req_cnt != base) begin failures++; $display("FAIL locked_no_req got=%0d exp=%0d", req_cnt, base); end
    endtask

    task automatic test_simultaneous();
        pulse_restart();
        restart = 1'b1; stb = 1'b1; we = 1'b1; data_in = 16'h0008;
        cyc(1);
        restart = 1'b0; stb = 1'b0; we = 1'b0; data_in = 16'h0;
        rd_bus(rd);
        checks++; if (rd !== 32'h0000_1505) begin failures++; $display("FAIL restart_beats_confirm got=%h exp=00001505", rd); end
        checks++; if (restart_req !== 1'b0) begin failures++; $display("FAIL restart_fail_no_req got=%b exp=0", restart_req); end
        wr(16'h0006);
        checks++; if (armed_out !== 1'b0) begin failures++; $display("FAIL disarm_beats_arm got=%b exp=0", armed_out); end
        rd_bus(rd);
        checks++; if (rd !== 32'h0000_1405) begin failures++; $display("FAIL disarm_read got=%h exp=00001405", rd); end
        wr(16'h0002);
        checks++; if (armed_out !== 1'b1) begin failures++; $display("FAIL rearm got=%b exp=1", armed_out); end
        pulse_restart();
        rd_bus(rd);
        checks++; if (rd !== 32'h0000_2505) begin failures++; $display("FAIL boot_fail2_read got=%h exp=00002505", rd); end
    endtask

    task automatic test_reset_mid_boot();
        base = req_cnt;
        #2 rst = 1'b0;
        #1;
        checks++; if (table_sel !== 8'h00) begin failures++; $display("FAIL midboot_table_sel got=%h exp=00", table_sel); end
        checks++; if (armed_out !== 1'b1) begin failures++; $display("FAIL midboot_armed got=%b exp=1", armed_out); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL midboot_locked got=%b exp=0", locked); end
        checks++; if (restart_req !== 1'b0) begin failures++; $display("FAIL midboot_req got=%b exp=0", restart_req); end
        rd_bus(rd);
        checks++; if (rd !== 32'h0000_0100) begin failures++; $display("FAIL midboot_read got=%h exp=00000100", rd); end
        cyc(3);
        rst = 1'b1;
        cyc(20);
        checks++; if (req_cnt != base) begin failures++; $display("FAIL midboot_no_req_after got=%0d exp=%0d", req_cnt, base); end
        rd_bus(rd);
        checks++; if (rd !== 32'h0000_0100) begin failures++; $display("FAIL midboot_resume_run got=%h exp=00000100", rd); end
    endtask

    initial begin
        test_reset();
        test_table_write();
        test_confirm();
        test_timeout();
        test_locked();
        test_simultaneous();
        test_reset_mid_boot();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
